spi_byte_cmd_decoder: RTL and testbench

- Front-end command decoder for the byte-parallel host port: chip select (active-low) plus one 8-bit host byte per clock.
- Parses the byte stream into register-file write/read transactions and stream bytes for the processing core downstream.
- Stream bytes are buffered in a small FIFO with a valid/ready handshake, because the host has no flow control.
- Sits between the top-level pin mapping and the register file / core.

---
 rtl/spi_cmd_pkg.sv | 18 +
 rtl/sync_fifo.sv | 68 ++++++
 rtl/spi_byte_cmd_decoder.sv | 139 +++++++++++++
 tb/tb_spi_byte_cmd_decoder.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_cmd_pkg.sv
// Shared command encodings and FSM state codes for the host byte-port decoder.
// Latency: n/a (constants only).
// Backpressure: n/a.
package spi_cmd_pkg;

  localparam logic [7:0] CMD_WRITE  = 8'h02;
  localparam logic [7:0] CMD_READ   = 8'h03;
  localparam logic [7:0] CMD_STREAM = 8'h80;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_W_ADDR = 3'd1;
  localparam state_t ST_W_DATA = 3'd2;
  localparam state_t ST_R_ADDR = 3'd3;
  localparam state_t ST_S_DATA = 3'd4;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous first-word-fall-through FIFO, DEPTH a power of two.
// Latency: a pushed entry appears on pop_data_o one cycle after the push edge.
// Backpressure: push while full is dropped unless a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       pop_data_o,
  output logic                   full_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic [AW:0]      count_d;
  logic             empty;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign count_o = count_q;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_pop  = pop_i & ~empty;
  assign do_push = push_i & (~full_o | do_pop);

  // Empty output reads as zero so the idle bus is clean.
  assign pop_data_o = empty ? '0 : mem_q[rd_ptr_q];

  // Occupancy bookkeeping for simultaneous push/pop.
  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/spi_byte_cmd_decoder.sv
// Decodes the byte-parallel host stream into register write/read strobes and stream bytes.
// Latency: wr_en/rd_en one edge after the last command byte; tx_byte two edges after the read address; stream byte visible one edge after sampling.
// Backpressure: host cannot be stalled; stream bytes arriving at a full FIFO are dropped and flagged in sticky ovf.
module spi_byte_cmd_decoder
  import spi_cmd_pkg::*;
#(
  parameter int ADDR_W     = 5,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs_n,
  input  logic [7:0]        rx_byte,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic [7:0]        tx_byte,
  output logic [7:0]        s_data,
  output logic              s_valid,
  input  logic              s_ready,
  output logic              ovf,
  input  logic              ovf_clr
);

  state_t                    state_q, state_d;
  logic [ADDR_W-1:0]         addr_q;
  logic                      wr_go, rd_go, push, pop;
  logic                      fifo_full;
  logic [$clog2(FIFO_DEPTH):0] fifo_cnt;

  logic              wr_en_q, rd_en_q, rd_pend_q, ovf_q;
  logic [ADDR_W-1:0] wr_addr_q, rd_addr_q;
  logic [7:0]        wr_data_q, tx_q;

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign rd_en   = rd_en_q;
  assign rd_addr = rd_addr_q;
  assign tx_byte = tx_q;
  assign ovf     = ovf_q;
  assign s_valid = (fifo_cnt != '0);
  assign pop     = s_valid & s_ready;

  // Next state and per-byte actions; deselect drops any partial command.
  always_comb begin
    state_d = ST_IDLE;
    wr_go   = 1'b0;
    rd_go   = 1'b0;
    push    = 1'b0;
    if (!cs_n) begin
      case (state_q)
        ST_IDLE: begin
          case (rx_byte)
            CMD_WRITE:  state_d = ST_W_ADDR;
            CMD_READ:   state_d = ST_R_ADDR;
            CMD_STREAM: state_d = ST_S_DATA;
            default:    state_d = ST_IDLE;
          endcase
        end
        ST_W_ADDR: state_d = ST_W_DATA;
        ST_W_DATA: wr_go   = 1'b1;
        ST_R_ADDR: rd_go   = 1'b1;
        ST_S_DATA: push    = 1'b1;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // FSM state and the write address captured between command and data bytes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      if (!cs_n && state_q == ST_W_ADDR) addr_q <= rx_byte[ADDR_W-1:0];
    end
  end

  // One-cycle strobes; address/data hold until the next command of the same kind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= 8'h00;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
    end else begin
      wr_en_q <= wr_go;
      rd_en_q <= rd_go;
      if (wr_go) begin
        wr_addr_q <= addr_q;
        wr_data_q <= rx_byte;
      end
      if (rd_go) rd_addr_q <= rx_byte[ADDR_W-1:0];
    end
  end

  // Register file answers the cycle after rd_en, so capture one edge later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pend_q <= 1'b0;
      tx_q      <= 8'h00;
    end else begin
      rd_pend_q <= rd_en_q;
      if (rd_pend_q) tx_q <= rd_data;
    end
  end

  // Sticky overflow; a clear wins over a same-cycle overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (ovf_clr) begin
      ovf_q <= 1'b0;
    end else if (push && fifo_full && !pop) begin
      ovf_q <= 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_stream_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (rx_byte),
    .pop_i       (pop),
    .pop_data_o  (s_data),
    .full_o      (fifo_full),
    .count_o     (fifo_cnt)
  );

endmodule

// File: tb/tb_spi_byte_cmd_decoder.sv
// Scoreboard bench for spi_byte_cmd_decoder: directed scenarios then random traffic.
// A command-level model queues expected strobes/stream bytes; a negedge monitor compares.
// Host has no stall, so the model drops stream bytes when its own queue holds DEPTH entries.
module tb_spi_byte_cmd_decoder;
  import spi_cmd_pkg::*;

  localparam int ADDR_W = 5;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst, cs_n, s_ready, ovf_clr;
  logic [7:0]        rx_byte, rd_data, wr_data, tx_byte, s_data;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic              wr_en, rd_en, s_valid, ovf;

  int n_vec = 0;
  int n_err = 0;
  logic mon_en = 1'b0;

  logic [7:0] regmem [32];

  // Model state
  logic [7:0]  cmd [$];
  logic [12:0] wr_exp [$];
  logic [4:0]  rd_exp [$];
  logic [7:0]  s_exp [$];
  logic [7:0]  tx_m;
  logic        ovf_m;
  logic        s1_v, s2_v;
  logic [4:0]  s1_a, s2_a;
  logic [7:0]  b0, b1, b2;
  logic [12:0] mw;
  logic [4:0]  mr;

  always #5 clk = ~clk;

  spi_byte_cmd_decoder #(.ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .cs_n(cs_n), .rx_byte(rx_byte),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .tx_byte(tx_byte), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .ovf(ovf), .ovf_clr(ovf_clr)
  );

  // Register file responder: data appears the cycle after rd_en.
  always @(posedge clk) if (rd_en) rd_data <= regmem[rd_addr];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Command-level reference: collect bytes of the current command, act when complete.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd.delete(); wr_exp.delete(); rd_exp.delete(); s_exp.delete();
      tx_m = 8'h00; ovf_m = 1'b0; s1_v = 1'b0; s2_v = 1'b0; s1_a = '0; s2_a = '0;
    end else begin
      if (s2_v) tx_m = regmem[s2_a];
      s2_v = s1_v; s2_a = s1_a; s1_v = 1'b0;
      if (cs_n) begin
        cmd.delete();
      end else begin
        cmd.push_back(rx_byte);
        b0 = cmd[0];
        if (b0 != CMD_WRITE && b0 != CMD_READ && b0 != CMD_STREAM) begin
          cmd.delete();
        end else if (b0 == CMD_WRITE && cmd.size() == 3) begin
          b1 = cmd[1]; b2 = cmd[2];
          wr_exp.push_back({b1[4:0], b2});
          cmd.delete();
        end else if (b0 == CMD_READ && cmd.size() == 2) begin
          b1 = cmd[1];
          rd_exp.push_back(b1[4:0]);
          s1_v = 1'b1; s1_a = b1[4:0];
          cmd.delete();
        end else if (b0 == CMD_STREAM && cmd.size() == 2) begin
          if (s_exp.size() < DEPTH) s_exp.push_back(cmd[1]);
          else ovf_m = 1'b1;
          cmd.delete();
        end
      end
      if (ovf_clr) ovf_m = 1'b0;
    end
  end

  // Monitor: compare every cycle away from the active edge.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      chk("wr_en", 32'(wr_en), 32'(wr_exp.size() != 0));
      if (wr_exp.size() != 0) begin
        mw = wr_exp.pop_front();
        if (wr_en) begin
          chk("wr_addr", 32'(wr_addr), 32'(mw[12:8]));
          chk("wr_data", 32'(wr_data), 32'(mw[7:0]));
        end
      end
      chk("rd_en", 32'(rd_en), 32'(rd_exp.size() != 0));
      if (rd_exp.size() != 0) begin
        mr = rd_exp.pop_front();
        if (rd_en) chk("rd_addr", 32'(rd_addr), 32'(mr));
      end
      chk("tx_byte", 32'(tx_byte), 32'(tx_m));
      chk("ovf", 32'(ovf), 32'(ovf_m));
      chk("s_valid", 32'(s_valid), 32'(s_exp.size() != 0));
      if (s_exp.size() != 0) begin
        chk("s_data", 32'(s_data), 32'(s_exp[0]));
        if (s_ready) void'(s_exp.pop_front());
      end
    end
  end

  task automatic drive(input logic cs, input logic [7:0] b, input logic rdy, input logic clr);
    @(posedge clk); #1;
    cs_n = cs; rx_byte = b; s_ready = rdy; ovf_clr = clr;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) drive(1'b1, 8'h00, rdy, 1'b0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_wr_en"},   32'(wr_en),   32'h0);
    chk({tag, "_rd_en"},   32'(rd_en),   32'h0);
    chk({tag, "_wr_addr"}, 32'(wr_addr), 32'h0);
    chk({tag, "_wr_data"}, 32'(wr_data), 32'h0);
    chk({tag, "_rd_addr"}, 32'(rd_addr), 32'h0);
    chk({tag, "_tx_byte"}, 32'(tx_byte), 32'h0);
    chk({tag, "_s_valid"}, 32'(s_valid), 32'h0);
    chk({tag, "_s_data"},  32'(s_data),  32'h0);
    chk({tag, "_ovf"},     32'(ovf),     32'h0);
  endtask

  // Assert reset just after an edge, check outputs cleared before the next edge.
  task automatic reset_mid(input string tag);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_reset_vals(tag);
    cs_n = 1'b1; s_ready = 1'b0; ovf_clr = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  logic [7:0] rb;

  initial begin
    rst = 1'b0; cs_n = 1'b1; rx_byte = 8'h00; s_ready = 1'b0; ovf_clr = 1'b0;
    for (int i = 0; i < 32; i++) regmem[i] = 8'($urandom);
    regmem[16] = 8'hA5;
    #1 rst = 1'b1;
    #2;
    check_reset_vals("por");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b1;

    // Write 02,00,61
    drive(0, CMD_WRITE, 0, 0); drive(0, 8'h00, 0, 0); drive(0, 8'h61, 0, 0);
    idle(3, 0);
    // Read 03,10 -> tx A5, held while idle
    drive(0, CMD_READ, 0, 0); drive(0, 8'h10, 0, 0);
    idle(6, 0);
    // Back-to-back writes
    drive(0, CMD_WRITE, 0, 0); drive(0, 8'h03, 0, 0); drive(0, 8'h11, 0, 0);
    drive(0, CMD_WRITE, 0, 0); drive(0, 8'hE4, 0, 0); drive(0, 8'h22, 0, 0);
    idle(2, 0);
    // Fill stream FIFO without draining
    for (int i = 0; i < 4; i++) begin
      drive(0, CMD_STREAM, 0, 0); drive(0, 8'h61 + 8'(i), 0, 0);
    end
    idle(2, 0);
    // Fifth byte overflows
    drive(0, CMD_STREAM, 0, 0); drive(0, 8'h65, 0, 0);
    idle(2, 0);
    drive(1, 8'h00, 0, 1);
    idle(2, 0);
    // Overflow together with clear
    drive(0, CMD_STREAM, 0, 0); drive(0, 8'h66, 0, 1);
    idle(2, 0);
    // Drain
    idle(6, 1);
    // Push while full with a same-cycle pop
    for (int i = 0; i < 4; i++) begin
      drive(0, CMD_STREAM, 0, 0); drive(0, 8'h70 + 8'(i), 0, 0);
    end
    drive(0, CMD_STREAM, 0, 0); drive(0, 8'h74, 1, 0);
    idle(8, 1);
    // Abort partial write, then invalid command followed by a write
    drive(0, CMD_WRITE, 0, 0); drive(0, 8'h05, 0, 0);
    idle(2, 0);
    drive(0, 8'h7F, 0, 0); drive(0, CMD_WRITE, 0, 0); drive(0, 8'h01, 0, 0); drive(0, 8'h33, 0, 0);
    idle(3, 0);
    // Reset in W_DATA with a non-empty FIFO
    drive(0, CMD_STREAM, 0, 0); drive(0, 8'hAA, 0, 0);
    drive(0, CMD_STREAM, 0, 0); drive(0, 8'hBB, 0, 0);
    drive(0, CMD_WRITE, 0, 0); drive(0, 8'h05, 0, 0);
    reset_mid("rst_wdata");
    // Reset while a write strobe is high
    drive(0, CMD_READ, 0, 0); drive(0, 8'h10, 0, 0);
    drive(0, CMD_WRITE, 0, 0); drive(0, 8'h07, 0, 0); drive(0, 8'h77, 0, 0);
    reset_mid("rst_strobe");
    // Decoding resumes normally
    drive(0, CMD_WRITE, 0, 0); drive(0, 8'h03, 0, 0); drive(0, 8'h44, 0, 0);
    drive(0, CMD_READ, 0, 0); drive(0, 8'h03, 0, 0);
    idle(4, 0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 4))
        0:       rb = CMD_WRITE;
        1:       rb = CMD_READ;
        2:       rb = CMD_STREAM;
        default: rb = 8'($urandom);
      endcase
      drive(($urandom_range(0, 9) == 0), rb, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 19) == 0));
    end

    idle(10, 1);
    mon_en = 1'b0;
    chk("sb_drain", 32'(wr_exp.size() + rd_exp.size() + s_exp.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
